// File: rtl/instr_pkg.sv
// Shared constants, FSM encoding and instruction classification for the
// RV32 LUI/ADDI/ADD/SUB decode/execute block.
package instr_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IMPL_MAX  = 3;

    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

    typedef enum logic [2:0] {
        OPC_LUI,
        OPC_ADDI,
        OPC_ADD,
        OPC_SUB,
        OPC_ILLEGAL
    } op_t;

    function automatic op_t classify(input logic [XLEN-1:0] w);
        op_t op;
        op = OPC_ILLEGAL;
        if (w[6:0] == OP_LUI) begin
            op = OPC_LUI;
        end else if (w[6:0] == OP_IMM && w[14:12] == F3_ADD) begin
            op = OPC_ADDI;
        end else if (w[6:0] == OP_REG && w[14:12] == F3_ADD) begin
            if (w[31:25] == F7_ADD) begin
                op = OPC_ADD;
            end else if (w[31:25] == F7_SUB) begin
                op = OPC_SUB;
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/operand_select.sv
// Maps an architectural register index onto the implemented register window;
// x0 and any unimplemented index read as zero.
module operand_select
    import instr_pkg::*;
#(
    parameter int unsigned REG_BASE = 5,
    parameter int unsigned NUM_REGS = 3
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [XLEN-1:0]      r0_value,
    input  logic [XLEN-1:0]      r1_value,
    input  logic [XLEN-1:0]      r2_value,
    output logic [XLEN-1:0]      value_c
);

    logic [XLEN-1:0] regs [IMPL_MAX];

    assign regs[0] = r0_value;
    assign regs[1] = r1_value;
    assign regs[2] = r2_value;

    always_comb begin
        value_c = '0;
        for (int unsigned i = 0; i < IMPL_MAX; i++) begin
            if (i < NUM_REGS && idx != '0 && 32'(idx) == REG_BASE + i) begin
                value_c = regs[i];
            end
        end
    end

endmodule

// File: rtl/instr_decode.sv
// Single-issue decode/execute/writeback sequencer for LUI, ADDI, ADD and SUB,
// driving the write port of an external register block.
module instr_decode
    import instr_pkg::*;
#(
    parameter int unsigned REG_BASE = 5,
    parameter int unsigned NUM_REGS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      instr_in,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [XLEN-1:0]      r0_value,
    input  logic [XLEN-1:0]      r1_value,
    input  logic [XLEN-1:0]      r2_value,
    output logic [REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]      rd_value,
    output logic                 we,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired_count
);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            load_wb;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] rs1_c;
    logic [XLEN-1:0] rs2_c;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] result_c;

    operand_select #(.REG_BASE(REG_BASE), .NUM_REGS(NUM_REGS)) u_rs1 (
        .idx      (instr_q[19:15]),
        .r0_value (r0_value),
        .r1_value (r1_value),
        .r2_value (r2_value),
        .value_c  (rs1_c)
    );

    operand_select #(.REG_BASE(REG_BASE), .NUM_REGS(NUM_REGS)) u_rs2 (
        .idx      (instr_q[24:20]),
        .r0_value (r0_value),
        .r1_value (r1_value),
        .r2_value (r2_value),
        .value_c  (rs2_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Illegal words leave DECODE straight back to IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_wb    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE:    state_next = illegal ? ST_IDLE : ST_EXECUTE;
            ST_EXECUTE: begin
                load_wb    = 1'b1;
                state_next = ST_WRITEBACK;
            end
            ST_WRITEBACK: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Operands are sampled during EXECUTE, after the predecessor's write landed.
    always_comb begin
        imm_c    = {{20{instr_q[31]}}, instr_q[31:20]};
        result_c = '0;
        case (classify(instr_q))
            OPC_LUI:  result_c = {instr_q[31:12], 12'b0};
            OPC_ADDI: result_c = rs1_c + imm_c;
            OPC_ADD:  result_c = rs1_c + rs2_c;
            OPC_SUB:  result_c = rs1_c - rs2_c;
            default:  result_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q       <= '0;
            instr_ready   <= 1'b1;
            illegal       <= 1'b0;
            we            <= 1'b0;
            rd            <= '0;
            rd_value      <= '0;
            retired_count <= '0;
        end else begin
            instr_ready <= (state_next == ST_IDLE);
            illegal     <= accept && (classify(instr_in) == OPC_ILLEGAL);
            we          <= load_wb && (instr_q[11:7] != '0);
            if (accept) begin
                instr_q <= instr_in;
            end
            if (load_wb) begin
                rd            <= instr_q[11:7];
                rd_value      <= result_c;
                retired_count <= CNT_W'(retired_count + 1'b1);
            end
        end
    end

endmodule
